// File: rtl/dxi_window_gen_if.sv
// dxi_window_gen_if: pixel-in / window-out handshake bundle for dxi_window_gen.
//   i_dxi_valid      upstream pixel valid
//   i_dxi_data[7:0]  upstream pixel (raster order)
//   o_dxi_ready      block can take a pixel
//   o_dxi_out_valid  3x3 window valid
//   o_dxi_out_data   packed 3x3 window (element i at [i*8 +: 8])
//   i_dxi_out_ready  filter stage takes the window
// slave modport = the window generator, master modport = its environment.
interface dxi_window_gen_if;
  logic        i_dxi_valid;
  logic [7:0]  i_dxi_data;
  logic        o_dxi_ready;
  logic        o_dxi_out_valid;
  logic [71:0] o_dxi_out_data;
  logic        i_dxi_out_ready;

  modport slave (
    input  i_dxi_valid, i_dxi_data, i_dxi_out_ready,
    output o_dxi_ready, o_dxi_out_valid, o_dxi_out_data
  );

  modport master (
    output i_dxi_valid, i_dxi_data, i_dxi_out_ready,
    input  o_dxi_ready, o_dxi_out_valid, o_dxi_out_data
  );
endinterface

// File: rtl/dxi_window_gen.sv
// dxi_window_gen: turns a raster pixel stream into 3x3 windows for a filter
// stage. Two line buffers hold rows r-2 and r-1; a 3x3 register window slides
// one column per accepted pixel. Windows are only emitted for fully interior
// positions (row>=2, col>=2), so a WxH frame yields (W-2)*(H-2) windows.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rstn         asynchronous active-low reset
//   dxi            dxi_window_gen_if.slave (pixel in, window out)
//   o_win_count    [15:0] completed output handshakes, wrapping
//                  (present only when DXI_WINDOW_CNT_EN is defined)
//
// Build option: define DXI_WINDOW_CNT_EN to add the o_win_count port.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_FILL  | rows 0 and 1 of a frame: priming the line buffers, no output
// ST_RUN   | rows 2..IMG_HEIGHT-1: windows produced for col>=2
module dxi_window_gen #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  dxi_window_gen_if.slave    dxi
`ifdef DXI_WINDOW_CNT_EN
  ,
  output logic [15:0]        o_win_count
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic {ST_FILL, ST_RUN} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [7:0]    lb0 [IMG_WIDTH];  // row r-1
  logic [7:0]    lb1 [IMG_WIDTH];  // row r-2
  logic [7:0]    win [3][3];       // win[dr][dc], dr=0 is the oldest row
  logic [7:0]    new_col [3];

  logic          out_valid_q;
  logic [71:0]   out_data_q;
  logic [71:0]   next_data;

  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          produce;

  assign dxi.o_dxi_ready     = !out_valid_q || dxi.i_dxi_out_ready;
  assign dxi.o_dxi_out_valid = out_valid_q;
  assign dxi.o_dxi_out_data  = out_data_q;

  assign accept   = dxi.i_dxi_valid && dxi.o_dxi_ready;
  assign col_last = (col == CW'(IMG_WIDTH - 1));
  assign row_last = (row == RW'(IMG_HEIGHT - 1));
  assign produce  = accept && (state == ST_RUN) && (col >= CW'(2));

  assign new_col[0] = lb1[col];
  assign new_col[1] = lb0[col];
  assign new_col[2] = dxi.i_dxi_data;

  // The outgoing window is the post-shift window, built directly from the
  // current registers so it can be captured on the same accepting edge.
  always_comb begin
    next_data = '0;
    for (int dr = 0; dr < 3; dr++) begin
      next_data[(3*dr)*8   +: 8] = win[dr][1];
      next_data[(3*dr+1)*8 +: 8] = win[dr][2];
      next_data[(3*dr+2)*8 +: 8] = new_col[dr];
    end
  end

  // Line buffers are deliberately not reset: rows 0/1 of every frame rewrite
  // them before any window reads them.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= dxi.i_dxi_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= ST_FILL;
      col         <= '0;
      row         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int dr = 0; dr < 3; dr++) begin
        for (int dc = 0; dc < 3; dc++) begin
          win[dr][dc] <= '0;
        end
      end
    end else begin
      if (accept) begin
        for (int dr = 0; dr < 3; dr++) begin
          win[dr][0] <= win[dr][1];
          win[dr][1] <= win[dr][2];
          win[dr][2] <= new_col[dr];
        end

        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end

        case (state)
          ST_FILL: if (col_last && row == RW'(1)) state <= ST_RUN;
          ST_RUN:  if (col_last && row_last)      state <= ST_FILL;
          default: state <= ST_FILL;
        endcase
      end

      // A producing acceptance always wins: it can only happen when the
      // output is empty or being drained this same edge.
      if (produce) begin
        out_valid_q <= 1'b1;
        out_data_q  <= next_data;
      end else if (dxi.i_dxi_out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef DXI_WINDOW_CNT_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_win_count <= '0;
    end else if (out_valid_q && dxi.i_dxi_out_ready) begin
      o_win_count <= o_win_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dxi_window_gen.sv
// tb_dxi_window_gen: drives a 4x4 and an 8x8 instance of dxi_window_gen.
// A frame-image model predicts every window from pixel coordinates; a
// compare loop checks outputs on each falling edge. Directed tests pin the
// model with literal windows and window counts.
module tb_dxi_window_gen;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  dxi_window_gen_if if4 ();
  dxi_window_gen_if if8 ();

  logic        vld [2];
  logic [7:0]  dat [2];
  logic        ordy_set [2];
  logic        rmode [2];
  logic        rbit [2];
  logic        ordy [2];
  logic        ov [2];
  logic        rdy [2];
  logic [71:0] od [2];
  logic [15:0] cnt4, cnt8;

  assign ordy[0] = rmode[0] ? rbit[0] : ordy_set[0];
  assign ordy[1] = rmode[1] ? rbit[1] : ordy_set[1];

  assign if4.i_dxi_valid     = vld[0];
  assign if4.i_dxi_data      = dat[0];
  assign if4.i_dxi_out_ready = ordy[0];
  assign if8.i_dxi_valid     = vld[1];
  assign if8.i_dxi_data      = dat[1];
  assign if8.i_dxi_out_ready = ordy[1];
  assign ov[0]  = if4.o_dxi_out_valid;
  assign rdy[0] = if4.o_dxi_ready;
  assign od[0]  = if4.o_dxi_out_data;
  assign ov[1]  = if8.o_dxi_out_valid;
  assign rdy[1] = if8.o_dxi_ready;
  assign od[1]  = if8.o_dxi_out_data;

  dxi_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .i_clk(clk), .i_rstn(rstn), .dxi(if4.slave)
`ifdef DXI_WINDOW_CNT_EN
    , .o_win_count(cnt4)
`endif
  );

  dxi_window_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) dut8 (
    .i_clk(clk), .i_rstn(rstn), .dxi(if8.slave)
`ifdef DXI_WINDOW_CNT_EN
    , .o_win_count(cnt8)
`endif
  );

`ifndef DXI_WINDOW_CNT_EN
  assign cnt4 = 16'd0;
  assign cnt8 = 16'd0;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;

  // model state
  logic [7:0]  img [2][8][8];
  int          pr [2];
  int          pc [2];
  logic [71:0] q0 [$];
  logic [71:0] q1 [$];
  logic [71:0] log0 [$];
  int          wins [2];
  logic        hold [2];
  logic [71:0] hold_d [2];

  function automatic int wid(int id);
    return (id == 0) ? 4 : 8;
  endfunction

  function automatic int qsz(int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  task automatic chk(string nm, logic [71:0] act, logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // Place the pixel at its (row,col) in the model image; interior positions
  // yield a window assembled straight from the image.
  task automatic model_accept(int id, logic [7:0] d);
    int r, c;
    logic [71:0] w;
    r = pr[id];
    c = pc[id];
    img[id][r][c] = d;
    if (r >= 2 && c >= 2) begin
      w = '0;
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          w[(3*dr+dc)*8 +: 8] = img[id][r-2+dr][c-2+dc];
      if (id == 0) q0.push_back(w); else q1.push_back(w);
    end
    c++;
    if (c == wid(id)) begin
      c = 0;
      r++;
      if (r == wid(id)) r = 0;
    end
    pr[id] = r;
    pc[id] = c;
  endtask

  task automatic mon_id(int id);
    logic [71:0] e;
    if (!rstn) begin
      if (id == 0) q0.delete(); else q1.delete();
      pr[id] = 0;
      pc[id] = 0;
      hold[id] = 1'b0;
      chk("rst_out_valid", ov[id], 0);
      return;
    end
    chk("out_valid", ov[id], qsz(id) != 0);
    chk("ready", rdy[id], !ov[id] || ordy[id]);
    if (hold[id] && ov[id]) chk("stall_stable", od[id], hold_d[id]);
    if (ov[id] && ordy[id]) begin
      if (qsz(id) == 0) begin
        fail_now("unexpected_window");
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk("window", od[id], e);
      end
      if (id == 0) log0.push_back(od[id]);
      wins[id]++;
    end
    hold[id]   = ov[id] && !ordy[id];
    hold_d[id] = od[id];
    if (vld[id] && rdy[id]) model_accept(id, dat[id]);
  endtask

  task automatic push_pixel(int id, logic [7:0] d, bit rv);
    bit acc;
    int b;
    if (rv) begin
      int g = 0;
      while ($urandom_range(0, 1) == 1 && g < 4) begin
        vld[id] = 1'b0;
        @(posedge clk); #1;
        g++;
      end
    end
    vld[id] = 1'b1;
    dat[id] = d;
    acc = 1'b0;
    b = 0;
    while (!acc) begin
      @(negedge clk);
      acc = rdy[id];
      @(posedge clk); #1;
      b++;
      if (!acc && b > 500) begin
        fail_now("pixel_accept_timeout");
        break;
      end
    end
  endtask

  task automatic send_frame(int id, bit flat, bit rv, int npix);
    for (int i = 0; i < npix; i++)
      push_pixel(id, flat ? 8'h5F : 8'(i), rv);
  endtask

  task automatic drain(int id);
    int b = 0;
    vld[id] = 1'b0;
    do begin
      @(posedge clk); #2;
      b++;
    end while ((ov[id] || qsz(id) != 0) && b < 1000);
    if (b >= 1000) fail_now("drain_timeout");
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_frame4(string nm, int w0);
    if (log0.size() < w0 + 4) begin
      fail_now({nm, "_missing_windows"});
    end else begin
      chk({nm, "_first"}, log0[w0],   72'h0A0908060504020100);
      chk({nm, "_last"},  log0[w0+3], 72'h0F0E0D0B0A09070605);
    end
  endtask

  initial begin
    int w0, w1, b;
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; dat[i] = 8'h00; ordy_set[i] = 1'b1;
      rmode[i] = 1'b0; rbit[i] = 1'b0;
      pr[i] = 0; pc[i] = 0; wins[i] = 0; hold[i] = 1'b0; hold_d[i] = '0;
    end
    fork
      forever begin
        @(negedge clk);
        mon_id(0);
        mon_id(1);
      end
      forever begin
        @(posedge clk); #1;
        rbit[0] = 1'($urandom_range(0, 1));
        rbit[1] = 1'($urandom_range(0, 1));
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready4", rdy[0], 1);
    chk("reset_data4", od[0], 72'h0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready8", rdy[1], 1);
    chk("post_reset_valid4", ov[0], 0);

    // single 4x4 frame, output always ready
    w0 = wins[0];
    send_frame(0, 1'b0, 1'b0, 16);
    drain(0);
    chk("frame4_count", wins[0] - w0, 4);
    check_frame4("frame4", w0);

    // output stalled after the first window for 10 cycles
    w0 = wins[0];
    ordy_set[0] = 1'b0;
    fork
      send_frame(0, 1'b0, 1'b0, 16);
      begin
        b = 0;
        do begin @(negedge clk); b++; end while (!ov[0] && b < 200);
        if (!ov[0]) fail_now("stall_first_window");
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("stall_ready_low", rdy[0], 0);
          chk("stall_data", od[0], 72'h0A0908060504020100);
        end
        @(posedge clk); #1;
        ordy_set[0] = 1'b1;
      end
    join
    drain(0);
    chk("stall_count", wins[0] - w0, 4);
    check_frame4("stall", w0);

    // two back-to-back frames, valid held high throughout
    w0 = wins[0];
    send_frame(0, 1'b0, 1'b0, 16);
    send_frame(0, 1'b0, 1'b0, 16);
    drain(0);
    chk("b2b_count", wins[0] - w0, 8);
    check_frame4("b2b_f1", w0);
    check_frame4("b2b_f2", w0 + 4);

    // reset after pixel 0x06, then a clean frame
    send_frame(0, 1'b0, 1'b0, 7);
    vld[0] = 1'b0;
    do_reset();
    w0 = wins[0];
    send_frame(0, 1'b0, 1'b0, 16);
    drain(0);
    chk("midreset_count", wins[0] - w0, 4);
    check_frame4("midreset", w0);

    // 8x8 flat frame with random valid gaps and random output ready
    w1 = wins[1];
    rmode[1] = 1'b1;
    send_frame(1, 1'b1, 1'b1, 64);
    drain(1);
    rmode[1] = 1'b0;
    chk("flat8_count", wins[1] - w1, 36);

`ifdef DXI_WINDOW_CNT_EN
    do_reset();
    chk("cnt_after_reset", cnt4, 16'd0);
    send_frame(0, 1'b0, 1'b0, 16);
    send_frame(0, 1'b0, 1'b0, 16);
    drain(0);
    chk("cnt_two_frames", cnt4, 16'd8);
    do_reset();
    chk("cnt_reset_again", cnt4, 16'd0);
    chk("cnt8_reset", cnt8, 16'd0);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
